// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and memory port.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                if_req;
   logic [ADDR_W-1:0]   if_addr;
   logic                if_kill;
   logic                if_gnt;
   logic                if_rvalid;
   logic [DATA_W-1:0]   if_rdata;
   logic                if_err;

   logic                d_req;
   logic                d_we;
   logic [DATA_W/8-1:0] d_be;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_gnt;
   logic                d_rvalid;
   logic [DATA_W-1:0]   d_rdata;
   logic                d_err;

   logic                m_req;
   logic                m_we;
   logic [DATA_W/8-1:0] m_be;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic                m_gnt;
   logic                m_rvalid;
   logic [DATA_W-1:0]   m_rdata;

   modport slave (
      input  if_req, if_addr, if_kill,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  m_gnt, m_rvalid, m_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output m_req, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output if_req, if_addr, if_kill,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output m_gnt, m_rvalid, m_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  m_req, m_we, m_be, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed DATA priority.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic               clk,
   input logic               reset_n,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_owner;
   logic                r_kill;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_m_req;
   logic                r_m_we;
   logic [BE_W-1:0]     r_m_be;
   logic [ADDR_W-1:0]   r_m_addr;
   logic [DATA_W-1:0]   r_m_wdata;
   logic                r_if_rvalid;
   logic                r_if_err;
   logic [DATA_W-1:0]   r_if_rdata;
   logic                r_d_rvalid;
   logic                r_d_err;
   logic [DATA_W-1:0]   r_d_rdata;

   logic                w_to;
   logic                w_pick_d;
   logic                w_start;
   logic                w_gnt;
   logic                w_done;
   logic                w_err;
   logic                w_disc;

   assign w_to = (TIMEOUT_CYC != 0) &&
                 (r_cnt == CNT_W'(TIMEOUT_CYC));

   // owner encoding: 0 = FETCH, 1 = DATA
`ifdef MEM_ARB_RR_EN
   logic r_last;

   assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_last <= 1'b0;
      else if (w_gnt)
         r_last <= r_owner;
   end
`else
   assign w_pick_d = bus.d_req;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (bus.if_req | bus.d_req)
               w_next = S_REQ;
         S_REQ:
            if (bus.m_gnt)
               w_next = S_WAIT;
            else if (w_to)
               w_next = S_IDLE;
         S_WAIT:
            if (bus.m_rvalid | w_to)
               w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_start = 1'b0;
      w_gnt   = 1'b0;
      w_done  = 1'b0;
      w_err   = 1'b1;
      unique case (r_state)
         S_IDLE:
            w_start = bus.if_req | bus.d_req;
         S_REQ: begin
            w_gnt  = bus.m_gnt | w_to;
            w_done = ~bus.m_gnt & w_to;
         end
         S_WAIT: begin
            w_done = bus.m_rvalid | w_to;
            w_err  = ~bus.m_rvalid;
         end
         default: ;
      endcase
   end

   // a kill landing in the completion cycle still discards the response
   assign w_disc = r_kill | bus.if_kill;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (w_next != r_state)
         r_cnt <= '0;
      else if (r_state != S_IDLE && !w_to)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_owner     <= 1'b0;
         r_kill      <= 1'b0;
         r_m_req     <= 1'b0;
         r_m_we      <= 1'b0;
         r_m_be      <= '0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_if_rvalid <= 1'b0;
         r_if_err    <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rvalid  <= 1'b0;
         r_d_err     <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_if_err    <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_err     <= 1'b0;
         if (w_start) begin
            r_owner   <= w_pick_d;
            r_kill    <= 1'b0;
            r_m_req   <= 1'b1;
            r_m_we    <= w_pick_d & bus.d_we;
            r_m_be    <= w_pick_d ? bus.d_be : '1;
            r_m_addr  <= w_pick_d ? bus.d_addr : bus.if_addr;
            r_m_wdata <= w_pick_d ? bus.d_wdata : '0;
         end
         if (r_state != S_IDLE && !r_owner && bus.if_kill)
            r_kill <= 1'b1;
         if (w_gnt)
            r_m_req <= 1'b0;
         if (w_done) begin
            r_kill <= 1'b0;
            if (r_owner) begin
               r_d_rvalid <= 1'b1;
               r_d_err    <= w_err;
               if (w_err)
                  r_d_rdata <= '0;
               else if (!r_m_we)
                  r_d_rdata <= bus.m_rdata;
            end else if (!w_disc) begin
               r_if_rvalid <= 1'b1;
               r_if_err    <= w_err;
               r_if_rdata  <= w_err ? '0 : bus.m_rdata;
            end
         end
      end
   end

   assign bus.if_gnt    = w_gnt & ~r_owner;
   assign bus.d_gnt     = w_gnt & r_owner;
   assign bus.if_rvalid = r_if_rvalid;
   assign bus.if_err    = r_if_err;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rvalid  = r_d_rvalid;
   assign bus.d_err     = r_d_err;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.m_req     = r_m_req;
   assign bus.m_we      = r_m_we;
   assign bus.m_be      = r_m_be;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_wdata   = r_m_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Honors MEM_ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // model: ph 0 = port free, 1 = awaiting grant, 2 = awaiting response
   int          ph, age;
   bit          own_d, kill, last_d;
   bit          p_we;
   logic [3:0]  p_be;
   logic [31:0] p_addr, p_wdata;
   bit          e_ifrv, e_drv, e_iferr, e_derr, e_ifg, e_dg;
   logic [31:0] e_ifrd, e_drd;

   bit          f_pend, d_pend, d_we_v;
   logic [31:0] f_addr, d_addr_v, d_wdata_v;
   logic [3:0]  d_be_v;
   bit          rnd_req;
   int          mem_mode;

   task automatic model_reset();
      ph = 0; age = 0; own_d = 0; kill = 0; last_d = 0;
      e_ifrv = 0; e_drv = 0; e_iferr = 0; e_derr = 0;
      e_ifg = 0; e_dg = 0; e_ifrd = '0; e_drd = '0;
      f_pend = 0; d_pend = 0;
   endtask

   task automatic check_outputs();
      e_ifg = (ph == 1) && !own_d && (bus.m_gnt || age == TO);
      e_dg  = (ph == 1) &&  own_d && (bus.m_gnt || age == TO);
      chk("m_req", bus.m_req, ph == 1);
      if (ph == 1) begin
         chk("m_addr", bus.m_addr, p_addr);
         chk("m_we", bus.m_we, p_we);
         if (own_d) begin
            chk("m_be", bus.m_be, p_be);
            chk("m_wdata", bus.m_wdata, p_wdata);
         end
      end
      chk("if_gnt", bus.if_gnt, e_ifg);
      chk("d_gnt", bus.d_gnt, e_dg);
      chk("if_rvalid", bus.if_rvalid, e_ifrv);
      chk("d_rvalid", bus.d_rvalid, e_drv);
      chk("if_err", bus.if_err, e_iferr);
      chk("d_err", bus.d_err, e_derr);
      chk("if_rdata", bus.if_rdata, e_ifrd);
      chk("d_rdata", bus.d_rdata, e_drd);
   endtask

   task automatic finish_txn(input bit err, input logic [31:0] data);
      if (own_d) begin
         e_drv = 1; e_derr = err;
         if (err) e_drd = '0;
         else if (!p_we) e_drd = data;
      end else if (!kill) begin
         e_ifrv = 1; e_iferr = err;
         e_ifrd = err ? 32'h0 : data;
      end
      ph = 0; kill = 0;
   endtask

   task automatic model_update();
      e_ifrv = 0; e_drv = 0; e_iferr = 0; e_derr = 0;
      if (e_ifg) f_pend = 0;
      if (e_dg)  d_pend = 0;
      case (ph)
         0: if (bus.if_req || bus.d_req) begin
            if (bus.if_req && bus.d_req)
               own_d = RR ? !last_d : 1'b1;
            else
               own_d = bus.d_req;
            p_addr  = own_d ? bus.d_addr : bus.if_addr;
            p_we    = own_d && bus.d_we;
            p_be    = bus.d_be;
            p_wdata = bus.d_wdata;
            ph = 1; age = 0; kill = 0;
         end
         1: begin
            if (!own_d && bus.if_kill) kill = 1;
            if (e_ifg || e_dg) last_d = own_d;
            if (bus.m_gnt) begin ph = 2; age = 0; end
            else if (age == TO) finish_txn(1, 32'h0);
            else age++;
         end
         default: begin
            if (!own_d && bus.if_kill) kill = 1;
            if (bus.m_rvalid) finish_txn(0, bus.m_rdata);
            else if (age == TO) finish_txn(1, 32'h0);
            else age++;
         end
      endcase
   endtask

   task automatic drive();
      if (rnd_req) begin
         if (!f_pend && $urandom_range(9) < 4) begin
            f_pend = 1; f_addr = $urandom;
         end
         if (!d_pend && $urandom_range(9) < 4) begin
            d_pend = 1; d_we_v = 1'($urandom_range(1));
            d_be_v = 4'($urandom_range(15));
            d_addr_v = $urandom; d_wdata_v = $urandom;
         end
         bus.if_kill = ($urandom_range(9) == 0);
      end
      bus.if_req  = f_pend;
      bus.if_addr = f_addr;
      bus.d_req   = d_pend;
      bus.d_we    = d_we_v;
      bus.d_be    = d_be_v;
      bus.d_addr  = d_addr_v;
      bus.d_wdata = d_wdata_v;
      if (mem_mode == 1) begin
         bus.m_gnt = (ph == 1);
         bus.m_rvalid = (ph == 2);
         bus.m_rdata = $urandom;
      end else if (mem_mode == 2) begin
         bus.m_gnt = (ph == 1) ? ($urandom_range(9) < 3)
                               : ($urandom_range(19) == 0);
         bus.m_rvalid = (ph == 2) ? ($urandom_range(9) < 4)
                                  : ($urandom_range(19) == 0);
         bus.m_rdata = $urandom;
      end
   endtask

   task automatic step();
      #1;
      check_outputs();
      if (reset_n) model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         step();
      end
   endtask

   task automatic set_d(input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd);
      d_pend = 1; d_we_v = we; d_be_v = be;
      d_addr_v = a; d_wdata_v = wd;
   endtask

   initial begin
      bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_be = '0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
      f_addr = '0; d_we_v = 0; d_be_v = '0;
      d_addr_v = '0; d_wdata_v = '0;
      rnd_req = 0; mem_mode = 0;
      model_reset();
      @(posedge clk); #1;
      step();
      step();
      reset_n = 1'b1;

      // load 0x100, immediate grant and response
      set_d(0, 4'hF, 32'h100, 32'h0);
      drive(); step();
      bus.m_gnt = 1; drive(); #1;
      chk("tp_load_gnt", bus.d_gnt, 1);
      step();
      bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
      drive(); step();
      bus.m_rvalid = 0; drive(); #1;
      chk("tp_load_rvalid", bus.d_rvalid, 1);
      chk("tp_load_rdata", bus.d_rdata, 32'hDEADBEEF);
      chk("tp_load_err", bus.d_err, 0);
      step();

      // store ack leaves d_rdata alone
      set_d(1, 4'hF, 32'h104, 32'h12345678);
      mem_mode = 1;
      run(3);
      drive(); #1;
      chk("st_ack", bus.d_rvalid, 1);
      chk("st_rdata", bus.d_rdata, 32'hDEADBEEF);
      step();

      // ties: first to DATA, second depends on arbitration mode
      f_pend = 1; f_addr = 32'h0;
      set_d(1, 4'b0011, 32'h200, 32'hA5A5_0F0F);
      drive(); step();
      drive(); #1;
      chk("tie1_dgnt", bus.d_gnt, 1);
      step();
      set_d(0, 4'hF, 32'h300, 32'h0);
      run(12);

      // timeout with no memory grant
      mem_mode = 0; bus.m_gnt = 0; bus.m_rvalid = 0;
      f_pend = 1; f_addr = 32'h40;
      run(5);
      drive(); #1;
      chk("to_gnt", bus.if_gnt, 1);
      step();
      drive(); #1;
      chk("to_rvalid", bus.if_rvalid, 1);
      chk("to_err", bus.if_err, 1);
      chk("to_rdata", bus.if_rdata, 0);
      step();

      // fetch killed in WAIT
      f_pend = 1; f_addr = 32'h80;
      run(1);
      bus.m_gnt = 1; run(1);
      bus.m_gnt = 0; bus.if_kill = 1; run(1);
      bus.if_kill = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hCAFEF00D;
      run(1);
      bus.m_rvalid = 0;
      set_d(0, 4'hF, 32'h104, 32'h0);
      drive(); #1;
      chk("kill_rvalid", bus.if_rvalid, 0);
      chk("kill_rdata", bus.if_rdata, 0);
      step();
      bus.m_gnt = 1; drive(); #1;
      chk("kill_next_dgnt", bus.d_gnt, 1);
      step();
      bus.m_gnt = 0; mem_mode = 1;
      run(4);

      rnd_req = 1; mem_mode = 2;
      run(3000);

      // reset in WAIT, then a late response
      for (int i = 0; i < 200 && ph != 2; i++) run(1);
      rnd_req = 0; mem_mode = 0;
      reset_n = 1'b0;
      model_reset();
      bus.if_kill = 0; bus.m_gnt = 0; bus.m_rvalid = 1;
      drive(); step();
      drive(); step();
      reset_n = 1'b1;
      drive(); step();
      bus.m_rvalid = 0;
      run(3);

      rnd_req = 1; mem_mode = 2;
      run(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the core's single memory port between the instruction-fetch stage and the load/store (MEM) stage. Data requests come from decoded LOAD/STORE instructions (MemRead/MemWrite); fetch requests come from the PC unit. The block serialises them into one outstanding memory transaction at a time, routes the response back to the owner, discards fetches killed by a taken branch/jump, and bounds every transaction with a timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- TIMEOUT_CYC, 255, cycles allowed in REQ or in WAIT before forced error completion; 0 disables the timeout
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; hold with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  discard the current or pending fetch response (branch/jump redirect)
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_rvalid  out  1  one-cycle pulse: fetch response valid
- if_rdata  out  DATA_W  fetch data; held until the next fetch response
- if_err  out  1  qualifies if_rvalid; timeout occurred
- d_req  in  1  data request; hold with payload stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt, d_rvalid, d_err  out  1  as the corresponding if_* signals; d_rvalid also acknowledges stores
- d_rdata  out  DATA_W  load data; held until the next data response
- m_req  out  1  memory request, registered
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched payload of the owner
- m_gnt  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response or write acknowledgement
- m_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. Owner register: FETCH or DATA.
- IDLE: if either request is active, select a winner, latch its payload into the m_* registers, set the owner, and go to REQ. m_req rises on the next cycle. If neither request is active, stay in IDLE.
- Arbitration (default): DATA has priority over FETCH.
- REQ: m_req=1. On m_gnt, pulse the owner's x_gnt combinationally in the same cycle, drop m_req on the next edge, and go to WAIT.
- WAIT: on m_rvalid, capture m_rdata into the owner's x_rdata, pulse x_rvalid on the next cycle with x_err=0, and go to IDLE.
- Timeout: the counter clears on entry to REQ and on entry to WAIT.
  - Counter reaches TIMEOUT_CYC in REQ: pulse x_gnt, drop m_req, go to IDLE, and pulse x_rvalid with x_err=1 and x_rdata=0 on the next cycle.
  - Counter reaches TIMEOUT_CYC in WAIT: same error response, then go to IDLE.
- Kill: if_kill while FETCH owns the port in REQ or WAIT, or in the same cycle as the fetch response, sets a discard flag.
  - The memory transaction still completes normally.
  - if_rvalid and if_err stay suppressed; if_rdata is not updated.
  - The discard flag clears on return to IDLE.
  - if_kill in IDLE has no effect. if_kill never affects a DATA owner.
- Stray m_rvalid in IDLE or REQ, and m_gnt outside REQ, are ignored.
- Reset, including mid-transaction: the FSM goes to IDLE immediately and asynchronously. All outputs, payload registers, rdata registers, counter, discard flag and the last-grant flag (reset to FETCH) return to 0. No response is produced for the aborted transaction.

## Timing
- Minimum request-to-response (m_gnt in the first REQ cycle, m_rvalid one cycle later):
  - cycle 0: x_req seen in IDLE
  - cycle 1: m_req and m_gnt, x_gnt pulse
  - cycle 2: m_rvalid
  - cycle 3: x_rvalid
- Back-to-back transactions: the next arbitration happens in the IDLE cycle after WAIT (3-cycle minimum issue interval).
- Only one transaction is outstanding at any time.
- x_gnt and x_rvalid are never high for both requesters in the same cycle.
- m_* payload is stable for the whole time m_req is high.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester not granted last wins. The last-grant flag updates on each x_gnt and resets to FETCH, so DATA wins the first tie.
- MEM_ARB_RR_EN undefined: fixed DATA priority; the last-grant flag is not implemented.

## Test plan
- Load only, memory grants immediately: d_req, d_addr=0x100, m_rvalid with m_rdata=0xDEADBEEF one cycle after m_gnt -> d_gnt in cycle 1, d_rvalid in cycle 3, d_rdata=0xDEADBEEF, d_err=0.
- Simultaneous if_req (0x0) and d_req (store 0x200, d_be=4'b0011) -> without the macro, DATA is served first and FETCH next; with MEM_ARB_RR_EN, a second tie is granted to FETCH.
- Fetch killed: if_kill pulses in WAIT, then m_rvalid arrives -> no if_rvalid, if_rdata unchanged, FSM returns to IDLE, the next d_req is accepted.
- Timeout, TIMEOUT_CYC=4, m_gnt never asserted -> if_gnt pulses after 4 REQ cycles, and if_rvalid=1, if_err=1, if_rdata=0 on the next cycle.
- reset_n low in WAIT, then a late m_rvalid -> all outputs 0 immediately, no x_rvalid, FSM idles.
- Store ack: d_we=1 -> d_rvalid pulses and d_rdata is unchanged from the previous load.
